riscv_vector_wb_arbiter: RTL and testbench

Write-side front end of the vector/crypto register file (VRF). It accepts result packets from NUM_SRC producers (AES/SHA crypto units, vector LSU, etc.) over valid/ready. Each cycle it arbitrates up to two of them onto the VRF's two write ports (W1 = A, W2 = B) through registered outputs. It guarantees the VRF never receives x0 writes, out-of-range addresses, or two writes to the same register in one cycle.

---
 rtl/riscv_vector_pkg.sv | 25 ++
 rtl/riscv_vector_rr_pick.sv | 59 +++++
 rtl/riscv_vector_wb_arbiter.sv | 155 +++++++++++++++
 tb/tb_riscv_vector_wb_arbiter.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_vector_pkg.sv
// Shared types and defaults for the vector register file write path.
//   DEF_VADDR_WIDTH / DEF_VDATA_WIDTH : default VRF address / data widths
//   VRF_NUM_REGS                      : architectural vector registers decoded by the VRF
//   vwb_req_t                         : one producer write request {addr, data}
//   vwb_class_e                       : how the arbiter treats a valid request
package riscv_vector_pkg;

  localparam int DEF_VADDR_WIDTH = 6;
  localparam int DEF_VDATA_WIDTH = 256;
  localparam int VRF_NUM_REGS    = 32;

  typedef struct packed {
    logic [DEF_VADDR_WIDTH-1:0] addr;
    logic [DEF_VDATA_WIDTH-1:0] data;
  } vwb_req_t;

  // CLS_NULL: x0 target, consumed silently. CLS_ILLEGAL: address MSB set,
  // dropped and flagged. CLS_NORMAL: competes for a VRF write port.
  typedef enum logic [1:0] {
    CLS_NULL,
    CLS_ILLEGAL,
    CLS_NORMAL
  } vwb_class_e;

endpackage

// File: rtl/riscv_vector_rr_pick.sv
// Rotating two-winner picker.
//   req       : request mask, one bit per source
//   ptr       : source index that has top priority this cycle
//   conflict  : conflict[i][j]=1 means source j may not share a cycle with source i
//   first_oh  : one-hot first request found scanning ptr, ptr+1, ... mod N
//   second_oh : one-hot next request after first_oh that does not conflict with it
module riscv_vector_rr_pick #(
  parameter int N  = 3,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]        req,
  input  logic [PW-1:0]       ptr,
  input  logic [N-1:0][N-1:0] conflict,
  output logic [N-1:0]        first_oh,
  output logic [N-1:0]        second_oh
);

  logic [N-1:0] req_b;
  logic         found_a;
  logic         found_b;

  function automatic int rot(input logic [PW-1:0] p, input int k);
    return (int'(p) + k) % N;
  endfunction

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment; a path that leaves it unassigned infers a latch.
  always_comb begin
    first_oh  = '0;
    second_oh = '0;
    found_a   = 1'b0;
    found_b   = 1'b0;

    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (rot(ptr, k) == i && req[i] && !found_a) begin
          first_oh[i] = 1'b1;
          found_a     = 1'b1;
        end
      end
    end

    // Collision mask: drop the winner itself and anything aimed at its register.
    req_b = req & ~first_oh;
    for (int i = 0; i < N; i++) begin
      if (first_oh[i]) req_b = req_b & ~conflict[i];
    end

    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (rot(ptr, k) == i && req_b[i] && !found_b) begin
          second_oh[i] = 1'b1;
          found_b      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/riscv_vector_wb_arbiter.sv
// VRF write-back arbiter: merges NUM_SRC producer result streams onto the two
// VRF write ports with one cycle of registered latency.
//   clk_int, rst_n            : clock, asynchronous active-low reset
//   src_valid_i / src_ready_o : per-source handshake (ready is combinational)
//   src_addr_i / src_data_i   : per-source destination register and result
//   vw*_a_o, vw*_b_o          : VRF write ports A (higher priority) and B
//   err_o / err_src_o         : sticky illegal-address flag and first offender
// x0 writes are swallowed, addresses with the MSB set are dropped and flagged,
// and both ports never target the same register in one cycle.
module riscv_vector_wb_arbiter
  import riscv_vector_pkg::*;
#(
  parameter int  VADDR_WIDTH = DEF_VADDR_WIDTH,
  parameter int  VDATA_WIDTH = DEF_VDATA_WIDTH,
  parameter int  NUM_SRC     = 3,
  localparam int SRC_IDX_W   = $clog2(NUM_SRC)
) (
  input  logic                                clk_int,
  input  logic                                rst_n,
  input  logic [NUM_SRC-1:0]                  src_valid_i,
  output logic [NUM_SRC-1:0]                  src_ready_o,
  input  logic [NUM_SRC-1:0][VADDR_WIDTH-1:0] src_addr_i,
  input  logic [NUM_SRC-1:0][VDATA_WIDTH-1:0] src_data_i,
  output logic [VADDR_WIDTH-1:0]              vwaddr_a_o,
  output logic [VDATA_WIDTH-1:0]              vwdata_a_o,
  output logic                                vwe_a_o,
  output logic [VADDR_WIDTH-1:0]              vwaddr_b_o,
  output logic [VDATA_WIDTH-1:0]              vwdata_b_o,
  output logic                                vwe_b_o,
  output logic                                err_o,
  output logic [SRC_IDX_W-1:0]                err_src_o
);

  vwb_class_e                         cls [NUM_SRC];
  logic [NUM_SRC-1:0]                 normal_req;
  logic [NUM_SRC-1:0]                 illegal_hit;
  logic [NUM_SRC-1:0]                 drop_ok;
  logic [NUM_SRC-1:0][NUM_SRC-1:0]    same_addr;
  logic [NUM_SRC-1:0]                 grant_a;
  logic [NUM_SRC-1:0]                 grant_b;
  logic [SRC_IDX_W-1:0]               rr_q;
  logic [SRC_IDX_W-1:0]               rr_d;
  logic [SRC_IDX_W-1:0]               idx_a;
  logic [SRC_IDX_W-1:0]               idx_b;
  logic [SRC_IDX_W-1:0]               err_idx;
  logic [VADDR_WIDTH-1:0]             addr_a;
  logic [VADDR_WIDTH-1:0]             addr_b;
  logic [VDATA_WIDTH-1:0]             data_a;
  logic [VDATA_WIDTH-1:0]             data_b;

  function automatic logic [SRC_IDX_W-1:0] next_idx(input logic [SRC_IDX_W-1:0] idx);
    return (idx == SRC_IDX_W'(NUM_SRC - 1)) ? '0 : idx + SRC_IDX_W'(1);
  endfunction

  always_comb begin
    normal_req  = '0;
    illegal_hit = '0;
    drop_ok     = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_addr_i[i] == '0)                 cls[i] = CLS_NULL;
      else if (src_addr_i[i][VADDR_WIDTH-1])   cls[i] = CLS_ILLEGAL;
      else                                     cls[i] = CLS_NORMAL;
      normal_req[i]  = src_valid_i[i] && (cls[i] == CLS_NORMAL);
      illegal_hit[i] = src_valid_i[i] && (cls[i] == CLS_ILLEGAL);
      drop_ok[i]     = src_valid_i[i] && (cls[i] != CLS_NORMAL);
    end
  end

  // Only normal requests reach the picker, so plain address equality suffices.
  always_comb begin
    same_addr = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int j = 0; j < NUM_SRC; j++) begin
        if (i != j) same_addr[i][j] = (src_addr_i[i] == src_addr_i[j]);
      end
    end
  end

  riscv_vector_rr_pick #(
    .N  (NUM_SRC),
    .PW (SRC_IDX_W)
  ) u_pick (
    .req       (normal_req),
    .ptr       (rr_q),
    .conflict  (same_addr),
    .first_oh  (grant_a),
    .second_oh (grant_b)
  );

  always_comb begin
    addr_a  = '0;
    data_a  = '0;
    idx_a   = '0;
    addr_b  = '0;
    data_b  = '0;
    idx_b   = '0;
    err_idx = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_a[i]) begin
        addr_a = src_addr_i[i];
        data_a = src_data_i[i];
        idx_a  = SRC_IDX_W'(i);
      end
      if (grant_b[i]) begin
        addr_b = src_addr_i[i];
        data_b = src_data_i[i];
        idx_b  = SRC_IDX_W'(i);
      end
    end
    // Descending scan so the lowest illegal index is the one left standing.
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (illegal_hit[i]) err_idx = SRC_IDX_W'(i);
    end
    // Pointer moves past the last port-granted source; B is always later in rotation.
    rr_d = rr_q;
    if (|grant_b)      rr_d = next_idx(idx_b);
    else if (|grant_a) rr_d = next_idx(idx_a);
  end

  // Nothing is accepted while reset is held, so no source thinks it handed off a result.
  assign src_ready_o = rst_n ? (drop_ok | grant_a | grant_b) : '0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_int or negedge rst_n) begin
    if (!rst_n) begin
      vwe_a_o    <= 1'b0;
      vwaddr_a_o <= '0;
      vwdata_a_o <= '0;
      vwe_b_o    <= 1'b0;
      vwaddr_b_o <= '0;
      vwdata_b_o <= '0;
      rr_q       <= '0;
      err_o      <= 1'b0;
      err_src_o  <= '0;
    end else begin
      vwe_a_o <= |grant_a;
      vwe_b_o <= |grant_b;
      if (|grant_a) begin
        vwaddr_a_o <= addr_a;
        vwdata_a_o <= data_a;
      end
      if (|grant_b) begin
        vwaddr_b_o <= addr_b;
        vwdata_b_o <= data_b;
      end
      rr_q <= rr_d;
      if (!err_o && (|illegal_hit)) begin
        err_o     <= 1'b1;
        err_src_o <= err_idx;
      end
    end
  end

endmodule

// File: tb/tb_riscv_vector_wb_arbiter.sv
// Self-checking bench for riscv_vector_wb_arbiter: directed scenarios plus a
// randomized stream, all checked against a queue-based rotation model.
module tb_riscv_vector_wb_arbiter;
  import riscv_vector_pkg::*;

  localparam int N  = 3;
  localparam int AW = DEF_VADDR_WIDTH;
  localparam int DW = DEF_VDATA_WIDTH;
  localparam int PW = $clog2(N);

  logic                   clk_int = 1'b0;
  logic                   rst_n   = 1'b0;
  logic [N-1:0]           src_valid_i;
  logic [N-1:0]           src_ready_o;
  logic [N-1:0][AW-1:0]   src_addr_i;
  logic [N-1:0][DW-1:0]   src_data_i;
  logic [AW-1:0]          vwaddr_a_o, vwaddr_b_o;
  logic [DW-1:0]          vwdata_a_o, vwdata_b_o;
  logic                   vwe_a_o, vwe_b_o, err_o;
  logic [PW-1:0]          err_src_o;

  vwb_req_t     req [N];
  logic [N-1:0] req_v;
  logic [N-1:0] acc;

  int n_vec = 0;
  int n_err = 0;

  // Model state
  int            m_rr, m_err_src;
  bit            m_err, m_we_a, m_we_b;
  logic [AW-1:0] m_addr_a, m_addr_b;
  logic [DW-1:0] m_data_a, m_data_b;

  always #5 clk_int = ~clk_int;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      src_valid_i[i] = req_v[i];
      src_addr_i[i]  = req[i].addr;
      src_data_i[i]  = req[i].data;
    end
  end

  riscv_vector_wb_arbiter #(.VADDR_WIDTH(AW), .VDATA_WIDTH(DW), .NUM_SRC(N)) dut (
    .clk_int(clk_int), .rst_n(rst_n),
    .src_valid_i(src_valid_i), .src_ready_o(src_ready_o),
    .src_addr_i(src_addr_i), .src_data_i(src_data_i),
    .vwaddr_a_o(vwaddr_a_o), .vwdata_a_o(vwdata_a_o), .vwe_a_o(vwe_a_o),
    .vwaddr_b_o(vwaddr_b_o), .vwdata_b_o(vwdata_b_o), .vwe_b_o(vwe_b_o),
    .err_o(err_o), .err_src_o(err_src_o)
  );

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom();
    return d;
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return '0;
    if (r == 1) return {1'b1, (AW-1)'($urandom())};
    return AW'($urandom_range(1, 5));
  endfunction

  function automatic bit is_illegal(input logic [AW-1:0] a);
    return a[AW-1];
  endfunction

  task automatic model_reset();
    m_rr = 0; m_err = 0; m_err_src = 0;
    m_we_a = 0; m_we_b = 0;
    m_addr_a = '0; m_addr_b = '0; m_data_a = '0; m_data_b = '0;
  endtask

  task automatic set_src(input int i, input bit v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_v[i] = v; req[i].addr = a; req[i].data = d;
  endtask

  task automatic retire();
    for (int i = 0; i < N; i++) if (acc[i]) req_v[i] = 1'b0;
  endtask

  // One clock: predict ready from the rotation rules, then check the registered writes.
  task automatic step(input string tag);
    logic [N-1:0] e_rdy;
    int ga, gb;
    int order[$];
    bit hit;
    e_rdy = '0; ga = -1; gb = -1;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_rr + k) % N;
      if (req_v[i] && req[i].addr != 0 && !is_illegal(req[i].addr)) order.push_back(i);
    end
    for (int i = 0; i < N; i++)
      if (req_v[i] && (req[i].addr == 0 || is_illegal(req[i].addr))) e_rdy[i] = 1'b1;
    if (order.size() > 0) begin
      ga = order[0];
      e_rdy[ga] = 1'b1;
      for (int j = 1; j < order.size(); j++) begin
        if (gb < 0 && req[order[j]].addr != req[ga].addr) begin
          gb = order[j];
          e_rdy[gb] = 1'b1;
        end
      end
    end
    #1;
    n_vec++;
    if (src_ready_o !== e_rdy) begin
      n_err++;
      $display("FAIL %s ready: got %b exp %b", tag, src_ready_o, e_rdy);
    end
    acc = src_valid_i & src_ready_o;

    hit = 0;
    if (!m_err) begin
      for (int i = 0; i < N; i++) begin
        if (!hit && req_v[i] && is_illegal(req[i].addr)) begin
          hit = 1; m_err = 1; m_err_src = i;
        end
      end
    end
    m_we_a = (ga >= 0);
    m_we_b = (gb >= 0);
    if (ga >= 0) begin m_addr_a = req[ga].addr; m_data_a = req[ga].data; end
    if (gb >= 0) begin m_addr_b = req[gb].addr; m_data_b = req[gb].data; end
    if (gb >= 0)      m_rr = (gb + 1) % N;
    else if (ga >= 0) m_rr = (ga + 1) % N;

    @(posedge clk_int); #1;
    n_vec++;
    if ({vwe_a_o, vwe_b_o} !== {m_we_a, m_we_b}) begin
      n_err++;
      $display("FAIL %s we: got %b%b exp %b%b", tag, vwe_a_o, vwe_b_o, m_we_a, m_we_b);
    end
    n_vec++;
    if (vwaddr_a_o !== m_addr_a || vwdata_a_o !== m_data_a) begin
      n_err++;
      $display("FAIL %s port_a: got %h/%h exp %h/%h", tag, vwaddr_a_o, vwdata_a_o, m_addr_a, m_data_a);
    end
    n_vec++;
    if (vwaddr_b_o !== m_addr_b || vwdata_b_o !== m_data_b) begin
      n_err++;
      $display("FAIL %s port_b: got %h/%h exp %h/%h", tag, vwaddr_b_o, vwdata_b_o, m_addr_b, m_data_b);
    end
    n_vec++;
    if (err_o !== m_err || err_src_o !== PW'(m_err_src)) begin
      n_err++;
      $display("FAIL %s err: got %b/%0d exp %b/%0d", tag, err_o, err_src_o, m_err, m_err_src);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_int);
    rst_n = 1'b0;
    req_v = '0;
    acc   = '0;
    model_reset();
    repeat (2) @(negedge clk_int);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < N; i++) set_src(i, 1'b1, AW'(i + 1), rand_data());
    #2;
    n_vec++;
    if (src_ready_o !== '0) begin
      n_err++; $display("FAIL reset ready: got %b exp 000", src_ready_o);
    end
    n_vec++;
    if ({vwe_a_o, vwe_b_o, err_o, err_src_o, vwaddr_a_o, vwaddr_b_o} !== '0 ||
        vwdata_a_o !== '0 || vwdata_b_o !== '0) begin
      n_err++; $display("FAIL reset outputs: got we=%b%b err=%b src=%0d exp all zero",
                        vwe_a_o, vwe_b_o, err_o, err_src_o);
    end
    do_reset();
  endtask

  task automatic test_single();
    logic [DW-1:0] d;
    d = {(DW/8){8'hA5}};
    set_src(0, 1'b1, AW'(5), d);
    step("single");
    retire();
    n_vec++;
    if (vwe_a_o !== 1'b1 || vwaddr_a_o !== AW'(5) || vwdata_a_o !== d || vwe_b_o !== 1'b0) begin
      n_err++; $display("FAIL single write: got we=%b%b addr=%0d exp we=10 addr=5",
                        vwe_a_o, vwe_b_o, vwaddr_a_o);
    end
    step("single_idle");
    n_vec++;
    if ({vwe_a_o, vwe_b_o} !== 2'b00) begin
      n_err++; $display("FAIL single idle: got we=%b%b exp 00", vwe_a_o, vwe_b_o);
    end
  endtask

  task automatic test_all_three();
    do_reset();
    for (int i = 0; i < N; i++) set_src(i, 1'b1, AW'(i + 1), rand_data());
    step("all3_c0");
    n_vec++;
    if (acc !== 3'b011 || vwaddr_a_o !== AW'(1) || vwaddr_b_o !== AW'(2)) begin
      n_err++; $display("FAIL all3 c0: got acc=%b a=%0d b=%0d exp acc=011 a=1 b=2",
                        acc, vwaddr_a_o, vwaddr_b_o);
    end
    retire();
    step("all3_c1");
    n_vec++;
    if (acc !== 3'b100 || vwaddr_a_o !== AW'(3) || vwe_b_o !== 1'b0) begin
      n_err++; $display("FAIL all3 c1: got acc=%b a=%0d web=%b exp acc=100 a=3 web=0",
                        acc, vwaddr_a_o, vwe_b_o);
    end
    retire();
  endtask

  task automatic test_collision();
    do_reset();
    set_src(0, 1'b1, AW'(7), rand_data());
    set_src(1, 1'b1, AW'(7), rand_data());
    step("coll_c0");
    n_vec++;
    if (acc !== 3'b001 || vwe_b_o !== 1'b0) begin
      n_err++; $display("FAIL coll c0: got acc=%b web=%b exp acc=001 web=0", acc, vwe_b_o);
    end
    retire();
    step("coll_c1");
    n_vec++;
    if (acc !== 3'b010 || vwaddr_a_o !== AW'(7) || vwdata_a_o !== req[1].data) begin
      n_err++; $display("FAIL coll c1: got acc=%b a=%0d exp acc=010 a=7", acc, vwaddr_a_o);
    end
    retire();
  endtask

  task automatic test_null();
    do_reset();
    set_src(0, 1'b1, AW'(4), rand_data());
    set_src(1, 1'b1, AW'(0), rand_data());
    step("null");
    n_vec++;
    if (acc !== 3'b011 || vwaddr_a_o !== AW'(4) || vwe_b_o !== 1'b0) begin
      n_err++; $display("FAIL null: got acc=%b a=%0d web=%b exp acc=011 a=4 web=0",
                        acc, vwaddr_a_o, vwe_b_o);
    end
    retire();
    // rr now points at src1; src1 and src0 both normal -> src1 on A.
    set_src(0, 1'b1, AW'(8), rand_data());
    set_src(1, 1'b1, AW'(9), rand_data());
    step("null_rr");
    n_vec++;
    if (vwaddr_a_o !== AW'(9) || vwaddr_b_o !== AW'(8)) begin
      n_err++; $display("FAIL null rr: got a=%0d b=%0d exp a=9 b=8", vwaddr_a_o, vwaddr_b_o);
    end
    retire();
  endtask

  task automatic test_illegal();
    do_reset();
    set_src(2, 1'b1, AW'('h21), rand_data());
    step("illegal_c0");
    n_vec++;
    if (acc !== 3'b100 || err_o !== 1'b1 || err_src_o !== PW'(2) || vwe_a_o !== 1'b0) begin
      n_err++; $display("FAIL illegal c0: got acc=%b err=%b src=%0d wea=%b exp 100/1/2/0",
                        acc, err_o, err_src_o, vwe_a_o);
    end
    retire();
    set_src(0, 1'b1, AW'('h30), rand_data());
    step("illegal_c1");
    n_vec++;
    if (err_src_o !== PW'(2)) begin
      n_err++; $display("FAIL illegal sticky: got src=%0d exp 2", err_src_o);
    end
    retire();
    // Simultaneous illegal sources after reset: lowest index captured.
    do_reset();
    set_src(1, 1'b1, AW'('h3f), rand_data());
    set_src(2, 1'b1, AW'('h22), rand_data());
    step("illegal_multi");
    n_vec++;
    if (err_src_o !== PW'(1)) begin
      n_err++; $display("FAIL illegal lowest: got src=%0d exp 1", err_src_o);
    end
    retire();
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_src(0, 1'b1, AW'(9), rand_data());
    step("b2b_c0");
    req[0].data = rand_data();
    step("b2b_c1");
    n_vec++;
    if (vwe_a_o !== 1'b1 || vwaddr_a_o !== AW'(9) || vwdata_a_o !== req[0].data) begin
      n_err++; $display("FAIL b2b: got wea=%b a=%0d exp wea=1 a=9", vwe_a_o, vwaddr_a_o);
    end
    retire();
  endtask

  task automatic test_fairness();
    int cnt[N];
    do_reset();
    for (int i = 0; i < N; i++) begin
      cnt[i] = 0;
      set_src(i, 1'b1, AW'(i + 1), rand_data());
    end
    for (int c = 0; c < 30; c++) begin
      step("fair");
      for (int i = 0; i < N; i++) if (acc[i]) begin
        cnt[i]++;
        req[i].data = rand_data();
      end
    end
    for (int i = 0; i < N; i++) begin
      n_vec++;
      if (cnt[i] < 19 || cnt[i] > 21) begin
        n_err++; $display("FAIL fair src%0d: got %0d grants exp 20+-1", i, cnt[i]);
      end
    end
    // Reset mid-stream: enables drop at once, ready held low.
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({vwe_a_o, vwe_b_o} !== 2'b00 || src_ready_o !== '0) begin
      n_err++; $display("FAIL midreset: got we=%b%b ready=%b exp 00/000",
                        vwe_a_o, vwe_b_o, src_ready_o);
    end
    model_reset();
    @(negedge clk_int);
    rst_n = 1'b1;
    #1;
    for (int c = 0; c < 6; c++) begin
      step("post_reset");
      for (int i = 0; i < N; i++) if (acc[i]) req[i].data = rand_data();
    end
    req_v = '0;
    acc   = '0;
  endtask

  task automatic test_random(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      if (c % 60 == 0) do_reset();
      for (int i = 0; i < N; i++) begin
        if (!req_v[i] || acc[i]) begin
          if ($urandom_range(0, 3) != 0) set_src(i, 1'b1, rand_addr(), rand_data());
          else req_v[i] = 1'b0;
        end
      end
      step("random");
    end
  endtask

  initial begin
    req_v = '0;
    acc   = '0;
    for (int i = 0; i < N; i++) begin
      req[i].addr = '0;
      req[i].data = '0;
    end
    model_reset();
    test_reset();
    test_single();
    test_all_three();
    test_collision();
    test_null();
    test_illegal();
    test_back_to_back();
    test_fairness();
    test_random(400);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
